// File: rtl/effect_scheduler.sv
// ---------------------------------------------------------------------------
// effect_scheduler
//
// Purpose: runs one captured audio sample through up to four gain stages.
// The stages share an external multiplier through a req/ack handshake.
// Each sample is accepted on sample_end. Each enabled stage multiplies the
// running value by its Q1.15 coefficient. The final value is published on
// audio_output, where the codec reads it on sample_req.
//
// Ports:
//   clk          : audio_clk domain clock
//   reset        : asynchronous, active-high reset
//   sample_end   : pulse, new sample valid on audio_input
//   sample_req   : pulse, codec reads audio_output
//   audio_input  : signed 16-bit captured sample
//   audio_output : signed 16-bit processed sample (registered)
//   control      : stage enables, bit i enables stage i
//   mul_req      : request to the shared multiplier
//   mul_a, mul_b : multiplier operands (running sample, stage coefficient)
//   mul_ack      : pulse, mul_result valid
//   mul_result   : signed Q1.15 product scaled to 16 bits
//   busy         : high while a sample is being processed
//   overrun      : sticky, sample_end arrived while busy
//   underrun     : sticky, sample_req arrived while busy
//   timeout      : sticky, the multiplier did not answer in time
//
// Build option: define EFFECT_SCHEDULER_TIMEOUT_EN to abandon a
// multiplication after 255 cycles in WAIT. That stage is bypassed and timeout
// is set. Without the macro, WAIT waits indefinitely and timeout stays 0.
// ---------------------------------------------------------------------------
module effect_scheduler #(
  parameter logic [63:0] COEFS = 64'h4000_4000_4000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_end,
  input  logic        sample_req,
  input  logic [15:0] audio_input,
  output logic [15:0] audio_output,
  input  logic [3:0]  control,
  output logic        mul_req,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_ack,
  input  logic [15:0] mul_result,
  output logic        busy,
  output logic        overrun,
  output logic        underrun,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_stage, w_stage_nxt;
  logic [15:0] r_acc, w_acc_nxt;
  logic [3:0]  r_ctl, w_ctl_nxt;
  logic [15:0] r_out, w_out_nxt;
  logic        r_mul_req, w_mul_req_nxt;
  logic [15:0] r_mul_a, w_mul_a_nxt;
  logic [15:0] r_mul_b, w_mul_b_nxt;
  logic        r_overrun, w_overrun_nxt;
  logic        r_underrun, w_underrun_nxt;
  logic        w_expire;

  // Coefficient of a stage, taken from the packed parameter.
  function automatic logic [15:0] coef_sel(input logic [1:0] stage);
    coef_sel = COEFS[{stage, 4'd0} +: 16];
  endfunction

`ifdef EFFECT_SCHEDULER_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  // The counter holds 0 outside WAIT, so it starts from 0 on every WAIT entry.
  // A count of 254 in a WAIT cycle without an ack marks the 255th cycle.
  assign w_expire = (r_state == S_WAIT) && !mul_ack && (r_wait_cnt == 8'd254);

  // WAIT-cycle counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state != S_WAIT) begin
        r_wait_cnt <= 8'd0;
      end else begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      r_timeout <= r_timeout | w_expire;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Next-state and datapath decisions for the scheduler FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_stage_nxt    = r_stage;
    w_acc_nxt      = r_acc;
    w_ctl_nxt      = r_ctl;
    w_out_nxt      = r_out;
    w_mul_req_nxt  = r_mul_req;
    w_mul_a_nxt    = r_mul_a;
    w_mul_b_nxt    = r_mul_b;
    // A new sample or a read while busy is dropped and remembered.
    w_overrun_nxt  = r_overrun  | (sample_end && (r_state != S_IDLE));
    w_underrun_nxt = r_underrun | (sample_req && (r_state != S_IDLE));
    case (r_state)
      S_IDLE: begin
        if (sample_end) begin
          w_acc_nxt   = audio_input;
          w_ctl_nxt   = control;     // snapshot: later control edits wait for the next sample
          w_stage_nxt = 2'd0;
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        if (r_ctl[r_stage]) begin
          w_mul_req_nxt = 1'b1;
          w_mul_a_nxt   = r_acc;
          w_mul_b_nxt   = coef_sel(r_stage);
          w_state_nxt   = S_WAIT;
        end else if (r_stage == 2'd3) begin
          w_state_nxt = S_DONE;
        end else begin
          w_stage_nxt = r_stage + 2'd1;
          w_state_nxt = S_CHECK;
        end
      end
      S_WAIT: begin
        if (mul_ack || w_expire) begin
          w_mul_req_nxt = 1'b0;
          // On expiry the running value is kept, so the stage is bypassed.
          if (mul_ack) begin
            w_acc_nxt = mul_result;
          end else begin
            w_acc_nxt = r_acc;
          end
          if (r_stage == 2'd3) begin
            w_state_nxt = S_DONE;
          end else begin
            w_stage_nxt = r_stage + 2'd1;
            w_state_nxt = S_CHECK;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_out_nxt   = r_acc;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_mul_req_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_stage    <= 2'd0;
      r_acc      <= 16'd0;
      r_ctl      <= 4'd0;
      r_out      <= 16'd0;
      r_mul_req  <= 1'b0;
      r_mul_a    <= 16'd0;
      r_mul_b    <= 16'd0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stage    <= w_stage_nxt;
      r_acc      <= w_acc_nxt;
      r_ctl      <= w_ctl_nxt;
      r_out      <= w_out_nxt;
      r_mul_req  <= w_mul_req_nxt;
      r_mul_a    <= w_mul_a_nxt;
      r_mul_b    <= w_mul_b_nxt;
      r_overrun  <= w_overrun_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign audio_output = r_out;
  assign mul_req      = r_mul_req;
  assign mul_a        = r_mul_a;
  assign mul_b        = r_mul_b;
  assign busy         = (r_state != S_IDLE);
  assign overrun      = r_overrun;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_effect_scheduler.sv
`timescale 1ns/1ps
module tb_effect_scheduler;

  localparam logic [63:0] TB_COEFS = 64'h7000_5000_3000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_end;
  logic        sample_req;
  logic [15:0] audio_input;
  logic [15:0] audio_output;
  logic [3:0]  control;
  logic        mul_req;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_ack;
  logic [15:0] mul_result;
  logic        busy;
  logic        overrun;
  logic        underrun;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: published output and sticky flags.
  logic [15:0] exp_out;
  bit          exp_ovr;
  bit          exp_udr;
  bit          exp_tmo;
  logic [15:0] coef_tab [4];

  effect_scheduler #(.COEFS(TB_COEFS)) dut (
    .clk(clk), .reset(reset), .sample_end(sample_end), .sample_req(sample_req),
    .audio_input(audio_input), .audio_output(audio_output), .control(control),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack),
    .mul_result(mul_result), .busy(busy), .overrun(overrun),
    .underrun(underrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One sample through the DUT. The bench acts as the multiplier, with random
  // latency. The model tracks the running value as the last product returned.
  task automatic run_sample(input logic [3:0] ctl, input logic [15:0] din, input bit fixed,
                            input logic [15:0] r0, input logic [15:0] r1,
                            input bit pokes, input bit both);
    int          en[$];
    int          nreq;
    int          lat;
    int          cyc;
    bit          pend;
    logic [15:0] macc;
    logic [15:0] res;
    for (int i = 0; i < 4; i++) if (ctl[i]) en.push_back(i);
    control = ctl; audio_input = din; sample_end = 1'b1; sample_req = both;
    @(negedge clk);
    sample_end = 1'b0; sample_req = 1'b0;
    control = 4'($urandom); audio_input = 16'($urandom);
    check_val("busy_start", busy, 1);
    macc = din; nreq = 0; pend = 0; lat = 0; cyc = 0;
    while (busy && cyc < 500) begin
      check_val("out_hold", audio_output, exp_out);
      mul_ack = 1'b0; sample_req = 1'b0; sample_end = 1'b0;
      if (mul_req) begin
        if (!pend) begin
          pend = 1; nreq++; lat = $urandom_range(0, 4);
          check_val("req_in_range", nreq <= en.size(), 1);
        end
        if (nreq <= en.size()) begin
          check_val("mul_a", mul_a, macc);
          check_val("mul_b", mul_b, coef_tab[en[nreq-1]]);
        end
        if (lat == 0) begin
          res = fixed ? ((nreq == 1) ? r0 : r1) : 16'($urandom);
          mul_ack = 1'b1; mul_result = res; macc = res; pend = 0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mul_ack = 1'b1; mul_result = 16'($urandom);   // stray ack, must be ignored
      end
      if (pokes && $urandom_range(0, 5) == 0) begin sample_req = 1'b1; exp_udr = 1; end
      if (pokes && $urandom_range(0, 7) == 0) begin
        sample_end = 1'b1; audio_input = 16'($urandom); exp_ovr = 1;
      end
      @(negedge clk);
      cyc++;
    end
    mul_ack = 1'b0; sample_req = 1'b0; sample_end = 1'b0;
    check_val("done_in_time", cyc < 500, 1);
    exp_out = macc;
    check_val("audio_out", audio_output, exp_out);
    check_val("req_count", nreq, en.size());
    check_val("overrun", overrun, exp_ovr);
    check_val("underrun", underrun, exp_udr);
    check_val("timeout", timeout, exp_tmo);
    check_val("req_idle", mul_req, 0);
  endtask

  initial begin
    int          cyc;
    logic [15:0] din;
    coef_tab[0] = 16'h1000; coef_tab[1] = 16'h3000;
    coef_tab[2] = 16'h5000; coef_tab[3] = 16'h7000;
    reset = 1'b1; sample_end = 1'b0; sample_req = 1'b0; audio_input = 16'd0;
    control = 4'd0; mul_ack = 1'b0; mul_result = 16'd0;
    exp_out = 16'd0; exp_ovr = 0; exp_udr = 0; exp_tmo = 0;
    repeat (2) @(negedge clk);
    check_val("rst_out", audio_output, 0);
    check_val("rst_req", mul_req, 0);
    check_val("rst_a", mul_a, 0);
    check_val("rst_b", mul_b, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_flags", {overrun, underrun, timeout}, 0);
    reset = 1'b0;
    @(negedge clk);

    // All stages off: output appears six cycles after sample_end.
    control = 4'd0; audio_input = 16'h1234; sample_end = 1'b1;
    @(negedge clk);
    sample_end = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      check_val("c6_hold", audio_output, 0);
      check_val("c6_noreq", mul_req, 0);
      @(negedge clk);
    end
    check_val("c6_out", audio_output, 16'h1234);
    check_val("c6_idle", busy, 0);
    exp_out = 16'h1234;

    // Stages 0 and 2 with known products.
    run_sample(4'b0101, 16'h2000, 1, 16'h1000, 16'h0800, 0, 0);
    check_val("two_stage_out", audio_output, 16'h0800);

    // sample_end with sample_req in IDLE: accepted, no underrun.
    run_sample(4'b0000, 16'h5555, 0, 16'd0, 16'd0, 0, 1);
    check_val("both_out", audio_output, 16'h5555);

    // Randomized samples with busy-time pokes and idle reads.
    repeat (40) begin
      run_sample(4'($urandom), 16'($urandom), 0, 16'd0, 16'd0, 1, 0);
      if ($urandom_range(0, 1) == 1) begin
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
      end
    end

    // Reset while waiting on the multiplier; a later ack must be ignored.
    din = 16'h7abc;
    control = 4'b0001; audio_input = din; sample_end = 1'b1;
    @(negedge clk);
    sample_end = 1'b0;
    cyc = 0;
    while (!mul_req && cyc < 10) begin @(negedge clk); cyc++; end
    check_val("rw_req_seen", mul_req, 1);
    #2 reset = 1'b1;
    #1;
    check_val("rw_req_async", mul_req, 0);
    check_val("rw_out", audio_output, 0);
    check_val("rw_ops", {mul_a, mul_b}, 0);
    check_val("rw_flags", {busy, overrun, underrun, timeout}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_out = 16'd0; exp_ovr = 0; exp_udr = 0; exp_tmo = 0;
    mul_ack = 1'b1; mul_result = 16'hbeef;
    @(negedge clk);
    mul_ack = 1'b0;
    @(negedge clk);
    check_val("rw_after_busy", busy, 0);
    check_val("rw_after_out", audio_output, 0);
    check_val("rw_after_req", mul_req, 0);

`ifdef EFFECT_SCHEDULER_TIMEOUT_EN
    // No ack: the request is dropped after 255 WAIT cycles and the stage is bypassed.
    din = 16'h4321;
    control = 4'b0001; audio_input = din; sample_end = 1'b1;
    @(negedge clk);
    sample_end = 1'b0;
    cyc = 0;
    while (!mul_req && cyc < 10) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (mul_req && cyc < 400) begin @(negedge clk); cyc++; end
    check_val("tmo_cycles", cyc, 255);
    cyc = 0;
    while (busy && cyc < 20) begin @(negedge clk); cyc++; end
    check_val("tmo_flag", timeout, 1);
    check_val("tmo_out", audio_output, din);
    exp_out = din; exp_tmo = 1;
`endif

    // Regular operation after reset.
    run_sample(4'b1111, 16'h0f0f, 0, 16'd0, 16'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
